// File: rtl/vram_arbiter_pkg.sv
// Shared widths and the read-owner encoding for the video/data memory arbiter.
package vram_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Request/grant/return bundle for the VGA and CPU ports plus the memory macro side.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) ();

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;

  // Requesters and the memory macro
  modport master (
    output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    input  vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
    input  mem_addr, mem_we, mem_wdata
  );

  // The arbiter
  modport slave (
    input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
    output vga_gnt, vga_rvalid, vga_rdata, cpu_gnt, cpu_rvalid, cpu_rdata,
    output mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vram_arbiter_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port memory arbiter: VGA fetch has priority, CPU is guaranteed a slot
// after MAX_VGA_RUN consecutive VGA grants while it waits.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int MAX_VGA_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  vram_arbiter_if.slave bus,
  output logic [15:0] vga_miss_cnt
);

  logic [3:0] run_cnt;
  logic       cpu_starved;
  logic       vga_gnt;
  logic       cpu_gnt;
  owner_t     owner_reg;

  always_comb begin
    cpu_starved = bus.cpu_req && (run_cnt >= 4'(MAX_VGA_RUN));
    vga_gnt     = !rst && bus.vga_req && !cpu_starved;
    cpu_gnt     = !rst && bus.cpu_req && !vga_gnt;
  end

  assign bus.vga_gnt   = vga_gnt;
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.mem_addr  = cpu_gnt ? bus.cpu_addr : bus.vga_addr;
  assign bus.mem_we    = cpu_gnt && bus.cpu_we;
  assign bus.mem_wdata = bus.cpu_wdata;

  // Run length only matters while the CPU is actually waiting.
  sat_counter #(.W(4)) u_run_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (vga_gnt && bus.cpu_req),
    .clr   (cpu_gnt || !bus.cpu_req),
    .count (run_cnt)
  );

  sat_counter #(.W(16)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bus.vga_req && !vga_gnt),
    .clr   (1'b0),
    .count (vga_miss_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg <= OWN_NONE;
    end else if (vga_gnt) begin
      owner_reg <= OWN_VGA;
    end else if (cpu_gnt && !bus.cpu_we) begin
      owner_reg <= OWN_CPU;
    end else begin
      owner_reg <= OWN_NONE;
    end
  end

  // Gated by rst so a read granted just before reset never reports data.
  assign bus.vga_rvalid = !rst && (owner_reg == OWN_VGA);
  assign bus.cpu_rvalid = !rst && (owner_reg == OWN_CPU);
  assign bus.vga_rdata  = bus.mem_q;
  assign bus.cpu_rdata  = bus.mem_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed checks of grant priority, run limiting, read return, writes, reset and miss counting.
module tb_vram_arbiter;

  logic clk;
  logic rst;
  logic [15:0] miss1;
  logic [15:0] miss2;
  int checks;
  int errors;

  vram_arbiter_if bus ();
  vram_arbiter_if bus2 ();

  vram_arbiter #(.MAX_VGA_RUN(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .vga_miss_cnt (miss1)
  );

  vram_arbiter #(.MAX_VGA_RUN(1)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus2),
    .vga_miss_cnt (miss2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] mem2 [256];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_q <= mem[bus.mem_addr[7:0]];
  end

  always @(posedge clk) begin
    if (bus2.mem_we) mem2[bus2.mem_addr[7:0]] <= bus2.mem_wdata;
    bus2.mem_q <= mem2[bus2.mem_addr[7:0]];
  end

  function automatic logic [7:0] exp_data(input logic [23:0] a);
    return (a[7:0] == 8'hFF) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  task automatic idle();
    bus.vga_req = 1'b0;  bus.cpu_req = 1'b0;  bus.cpu_we = 1'b0;
    bus2.vga_req = 1'b0; bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vga_req = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
    bus.vga_addr = 24'h1; bus.cpu_addr = 24'h2; bus.cpu_wdata = 8'h11;
    bus2.vga_req = 1'b1; bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b0;
    bus2.vga_addr = 24'h1; bus2.cpu_addr = 24'h2; bus2.cpu_wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.vga_gnt !== 1'b0) begin errors++; $display("FAIL reset_vga_gnt: got %b want 0", bus.vga_gnt); end
    checks++; if (bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt: got %b want 0", bus.cpu_gnt); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    checks++; if ({bus.vga_rvalid, bus.cpu_rvalid} !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", {bus.vga_rvalid, bus.cpu_rvalid}); end
    checks++; if (miss1 !== 16'd0) begin errors++; $display("FAIL reset_miss: got %h want 0000", miss1); end
    checks++; if (bus2.vga_gnt !== 1'b0) begin errors++; $display("FAIL reset_dut2_gnt: got %b want 0", bus2.vga_gnt); end
    $display("reset: gnt=%b%b mem_we=%b miss=%h", bus.vga_gnt, bus.cpu_gnt, bus.mem_we, miss1);
    idle();
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_reads();
    @(negedge clk);
    bus.vga_req = 1'b1; bus.vga_addr = 24'h000010;
    #1;
    checks++; if ({bus.vga_gnt, bus.cpu_gnt} !== 2'b10) begin errors++; $display("FAIL single_vga_gnt: got %b want 10", {bus.vga_gnt, bus.cpu_gnt}); end
    checks++; if (bus.mem_addr !== 24'h000010) begin errors++; $display("FAIL single_vga_addr: got %h want 000010", bus.mem_addr); end
    @(negedge clk);
    bus.vga_req = 1'b0; bus.vga_addr = 24'h000033;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h000020;
    #1;
    checks++; if ({bus.vga_rvalid, bus.cpu_rvalid} !== 2'b10) begin errors++; $display("FAIL single_vga_rvalid: got %b want 10", {bus.vga_rvalid, bus.cpu_rvalid}); end
    checks++; if (bus.vga_rdata !== 8'h4A) begin errors++; $display("FAIL single_vga_rdata: got %h want 4a", bus.vga_rdata); end
    checks++; if ({bus.vga_gnt, bus.cpu_gnt} !== 2'b01) begin errors++; $display("FAIL single_cpu_gnt: got %b want 01", {bus.vga_gnt, bus.cpu_gnt}); end
    checks++; if (bus.mem_addr !== 24'h000020) begin errors++; $display("FAIL single_cpu_addr: got %h want 000020", bus.mem_addr); end
    $display("single: vga read 000010 -> %h", bus.vga_rdata);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    checks++; if ({bus.vga_rvalid, bus.cpu_rvalid} !== 2'b01) begin errors++; $display("FAIL single_cpu_rvalid: got %b want 01", {bus.vga_rvalid, bus.cpu_rvalid}); end
    checks++; if (bus.cpu_rdata !== 8'h7A) begin errors++; $display("FAIL single_cpu_rdata: got %h want 7a", bus.cpu_rdata); end
    checks++; if (bus.mem_addr !== 24'h000033) begin errors++; $display("FAIL idle_mem_addr: got %h want 000033", bus.mem_addr); end
    $display("single: cpu read 000020 -> %h", bus.cpu_rdata);
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 24'h0000FF; bus.cpu_wdata = 8'hA5;
    #1;
    checks++; if ({bus.cpu_gnt, bus.mem_we} !== 2'b11) begin errors++; $display("FAIL write_gnt_we: got %b want 11", {bus.cpu_gnt, bus.mem_we}); end
    checks++; if ({bus.mem_addr, bus.mem_wdata} !== {24'h0000FF, 8'hA5}) begin errors++; $display("FAIL write_addr_data: got %h/%h want 0000ff/a5", bus.mem_addr, bus.mem_wdata); end
    $display("write: addr=%h data=%h we=%b", bus.mem_addr, bus.mem_wdata, bus.mem_we);
    @(negedge clk);
    bus.cpu_we = 1'b0; bus.cpu_wdata = 8'h00;
    #1;
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid: got %b want 0", bus.cpu_rvalid); end
    checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL read_mem_we: got %b want 0", bus.mem_we); end
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    checks++; if ({bus.cpu_rvalid, bus.cpu_rdata} !== {1'b1, 8'hA5}) begin errors++; $display("FAIL write_readback: got %b/%h want 1/a5", bus.cpu_rvalid, bus.cpu_rdata); end
    $display("write: readback 0000ff -> %h", bus.cpu_rdata);
  endtask

  task automatic test_contention();
    logic prev_v;
    logic [23:0] prev_a;
    logic exp_c;
    prev_v = 1'b0; prev_a = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus.vga_req = 1'b1; bus.vga_addr = 24'(k);
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h000080;
      #1;
      exp_c = ((k % 5) == 4);
      checks++; if ({bus.vga_gnt, bus.cpu_gnt} !== {!exp_c, exp_c}) begin errors++; $display("FAIL contend_gnt[%0d]: got %b want %b", k, {bus.vga_gnt, bus.cpu_gnt}, {!exp_c, exp_c}); end
      if (k > 0) begin
        checks++; if ({bus.vga_rvalid, bus.cpu_rvalid} !== {prev_v, !prev_v}) begin errors++; $display("FAIL contend_rvalid[%0d]: got %b want %b", k, {bus.vga_rvalid, bus.cpu_rvalid}, {prev_v, !prev_v}); end
        checks++; if (bus.vga_rdata !== exp_data(prev_a)) begin errors++; $display("FAIL contend_rdata[%0d]: got %h want %h", k, bus.vga_rdata, exp_data(prev_a)); end
      end
      $display("contend: cycle %0d gnt v=%b c=%b", k, bus.vga_gnt, bus.cpu_gnt);
      prev_v = !exp_c;
      prev_a = exp_c ? 24'h000080 : 24'(k);
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (miss1 !== 16'd4) begin errors++; $display("FAIL contend_miss: got %0d want 4", miss1); end
  endtask

  task automatic test_cpu_drop();
    logic exp_c;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.vga_req = 1'b1; bus.vga_addr = 24'h40;
      bus.cpu_req = (i != 3); bus.cpu_we = 1'b0; bus.cpu_addr = 24'h41;
      #1;
      exp_c = (i == 8);
      checks++; if ({bus.vga_gnt, bus.cpu_gnt} !== {!exp_c, exp_c}) begin errors++; $display("FAIL drop_gnt[%0d]: got %b want %b", i, {bus.vga_gnt, bus.cpu_gnt}, {!exp_c, exp_c}); end
      if (i == 3) begin
        checks++; if (dut.run_cnt !== 4'd3) begin errors++; $display("FAIL drop_run_before: got %0d want 3", dut.run_cnt); end
      end
      if (i == 4) begin
        checks++; if (dut.run_cnt !== 4'd0) begin errors++; $display("FAIL drop_run_cleared: got %0d want 0", dut.run_cnt); end
      end
      $display("drop: cycle %0d cpu_req=%b gnt v=%b c=%b", i, bus.cpu_req, bus.vga_gnt, bus.cpu_gnt);
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (miss1 !== 16'd5) begin errors++; $display("FAIL drop_miss: got %0d want 5", miss1); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    bus.vga_req = 1'b1; bus.vga_addr = 24'h000050;
    #1;
    checks++; if (bus.vga_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b want 1", bus.vga_gnt); end
    @(negedge clk);
    rst = 1'b1; bus.cpu_req = 1'b1;
    #1;
    checks++; if (bus.vga_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid: got %b want 0", bus.vga_rvalid); end
    checks++; if ({bus.vga_gnt, bus.cpu_gnt} !== 2'b00) begin errors++; $display("FAIL rstmid_gnt_low: got %b want 00", {bus.vga_gnt, bus.cpu_gnt}); end
    @(negedge clk);
    #1;
    checks++; if (miss1 !== 16'd0) begin errors++; $display("FAIL rstmid_miss: got %0d want 0", miss1); end
    checks++; if (dut.run_cnt !== 4'd0) begin errors++; $display("FAIL rstmid_run: got %0d want 0", dut.run_cnt); end
    checks++; if ({bus.vga_rvalid, bus.cpu_rvalid} !== 2'b00) begin errors++; $display("FAIL rstmid_rvalid_after: got %b want 00", {bus.vga_rvalid, bus.cpu_rvalid}); end
    $display("reset mid-read: rvalid=%b miss=%0d", bus.vga_rvalid, miss1);
    idle();
    rst = 1'b0;
  endtask

  task automatic test_alternation();
    logic exp_c;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus2.vga_req = 1'b1; bus2.vga_addr = 24'(k);
      bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b0; bus2.cpu_addr = 24'h90;
      #1;
      exp_c = k[0];
      checks++; if ({bus2.vga_gnt, bus2.cpu_gnt} !== {!exp_c, exp_c}) begin errors++; $display("FAIL alt_gnt[%0d]: got %b want %b", k, {bus2.vga_gnt, bus2.cpu_gnt}, {!exp_c, exp_c}); end
      $display("alternate: cycle %0d gnt v=%b c=%b", k, bus2.vga_gnt, bus2.cpu_gnt);
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (miss2 !== 16'd4) begin errors++; $display("FAIL alt_miss: got %0d want 4", miss2); end
  endtask

  task automatic test_miss_saturation();
    @(negedge clk);
    force dut.u_miss_cnt.count_reg = 16'hFFFA;
    #1;
    release dut.u_miss_cnt.count_reg;
    checks++; if (miss1 !== 16'hFFFA) begin errors++; $display("FAIL sat_preload: got %h want fffa", miss1); end
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 5) begin
        #1;
        checks++; if (miss1 !== 16'hFFFB) begin errors++; $display("FAIL sat_step: got %h want fffb", miss1); end
      end
      bus.vga_req = 1'b1; bus.vga_addr = 24'h7;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 24'h8;
    end
    @(negedge clk);
    idle();
    #1;
    checks++; if (miss1 !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", miss1); end
    $display("saturation: miss=%h", miss1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i) ^ 8'h5A;
      mem2[i] = 8'(i) ^ 8'h5A;
    end
    test_reset();
    test_single_reads();
    test_cpu_write();
    test_contention();
    test_cpu_drop();
    test_reset_mid_read();
    test_alternation();
    test_miss_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video/data memory between the VGA scan-out fetch and the processor load/store port. VGA fetches have priority because they are real-time. A run limiter guarantees the processor one slot after a bounded number of back-to-back VGA grants. The block sits between `processor`, `vga` and the memory macro, replacing the direct `parallelAddress`/`q` connection in `MainConnection`.

## Interface
- `ADDR_W`, 24, address width (matches `parallelAddress`)
- `DATA_W`, 8, memory word width (matches `q`)
- `MAX_VGA_RUN`, 4, consecutive VGA grants allowed while the CPU is waiting; legal range 1..15
- `clk`  in  1  system clock (FPGA_CLK1_50 domain); one clock; reset is synchronous and active-high
- `rst`  in  1  synchronous, active-high reset
- `vga_req`  in  1  VGA fetch request
- `vga_addr`  in  ADDR_W  VGA fetch address
- `vga_gnt`  out  1  VGA request accepted this cycle
- `vga_rvalid`  out  1  `vga_rdata` valid
- `vga_rdata`  out  DATA_W  VGA read data
- `cpu_req`  in  1  CPU access request
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_gnt`  out  1  CPU request accepted this cycle
- `cpu_rvalid`  out  1  `cpu_rdata` valid (reads only)
- `cpu_rdata`  out  DATA_W  CPU read data
- `mem_addr`  out  ADDR_W  memory address
- `mem_we`  out  1  memory write enable
- `mem_wdata`  out  DATA_W  memory write data
- `mem_q`  in  DATA_W  memory read data, registered inside the macro (1-cycle latency)
- `vga_miss_cnt`  out  16  saturating count of cycles where `vga_req`=1 and `vga_gnt`=0

## Operation
- **Grant decision (combinational from the current state):**
  - If `rst` is high: no grant.
  - Otherwise, if `vga_req` and not (`cpu_req` and `run_cnt` ≥ `MAX_VGA_RUN`): grant VGA.
  - Otherwise, if `cpu_req`: grant CPU.
  - Otherwise: no grant.
  - At most one `gnt` is high per cycle.
- **Memory drive:**
  - `mem_addr` = address of the winner; `vga_addr` when there is no grant.
  - `mem_we` = `cpu_gnt & cpu_we`.
  - `mem_wdata` = `cpu_wdata`.
- **`run_cnt` (4-bit register):**
  - Incremented on a VGA grant while `cpu_req`=1, saturating at 15.
  - Cleared on a CPU grant.
  - Cleared on any cycle where `cpu_req`=0.
- **Owner register (`OWN_NONE`/`OWN_VGA`/`OWN_CPU`):** records the read winner each cycle.
  - A CPU write sets `OWN_NONE`, so a write never produces `rvalid`.
- **Read return:** the cycle after a read grant:
  - `*_rvalid` = 1 for the recorded owner.
  - Both `*_rdata` outputs present `mem_q`, registered-free pass-through.
  - The non-owner's `rdata` is don't-care.
- **`vga_miss_cnt`:** increments on every denied `vga_req` cycle and saturates at 0xFFFF.

## Timing
- **Reset values:**
  - Owner = `OWN_NONE`, `run_cnt` = 0, `vga_miss_cnt` = 0.
  - Both `rvalid` = 0 and both `gnt` = 0 while `rst` = 1.
  - `mem_we` = 0.
- **Latency:**
  - Request to grant: 0 cycles (same cycle).
  - Grant to `rvalid`: exactly 1 cycle.
  - Writes commit at the grant edge.
- **Throughput:** one access per cycle. Back-to-back grants to the same or different requesters are legal.
- **Handshake:**
  - A requester holds `req`/`addr`/`we`/`wdata` stable until it sees `gnt`.
  - A new request may be presented in the cycle after `gnt`.
- **Simultaneous requests:**
  - VGA wins until `run_cnt` reaches `MAX_VGA_RUN`.
  - Then the CPU wins exactly one cycle, `run_cnt` clears, and VGA priority resumes.
- **Reset mid-operation:** a read granted in the cycle before `rst` rises returns no `rvalid`. The owner is cleared synchronously.
- **`MAX_VGA_RUN` = 1:** strict alternation under continuous contention.

## Structure
- `vram_pkg`: `ADDR_W`, `DATA_W`, and the `owner_t` enum {`OWN_NONE`, `OWN_VGA`, `OWN_CPU`}.
- One sub-module, `sat_counter` (parameterised width, inc, clr, saturate), instanced twice:
  - for `run_cnt`;
  - for `vga_miss_cnt`.
- Everything else stays flat in `vram_arbiter`.

## Test plan
- **Idle then single reads:** `vga_req` at addr 0x000010 → `vga_gnt` the same cycle; next cycle `vga_rvalid`=1 with `mem_q`. Then a CPU read at 0x000020 → `cpu_rvalid` 1 cycle later, `vga_rvalid`=0.
- **Continuous contention, `MAX_VGA_RUN`=4:** both requests held for 20 cycles → grant pattern V,V,V,V,C repeating; `vga_miss_cnt` = 4 at the end.
- **CPU write:** `cpu_we`=1, addr 0x0000FF, wdata 0xA5 → `mem_we`=1 for one cycle with the correct addr/data, and no `cpu_rvalid`. A following CPU read of 0x0000FF returns 0xA5.
- **`cpu_req` drops mid-run:** 3 VGA grants under contention, then `cpu_req`=0 for one cycle → `run_cnt` clears; re-contention needs 4 fresh VGA grants before the CPU slot.
- **Reset mid-read:** VGA read granted, `rst`=1 on the next edge → `vga_rvalid`=0, both `gnt`=0, counters reset to 0.
- **Miss saturation:** force 0x10005 denied VGA cycles via a small `MAX_VGA_RUN` and long CPU windows (or preload) → `vga_miss_cnt` holds at 0xFFFF.
